// File: rtl/eth_mac_pkg.sv
// Shared constants, TX state encoding and the byte-wise CRC32 step for the
// Ethernet MAC transmit path.
package eth_mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  localparam int PREAMBLE_BYTES_DEF = 7;
  localparam int MIN_FRAME_SIZE_DEF = 64;
  localparam int MAX_FRAME_SIZE_DEF = 1518;
  localparam int IFG_BYTES_DEF      = 12;
  localparam int FCS_BYTES          = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } tx_state_e;

  // One byte of reflected CRC32, LSB of the data byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_mac_crc32.sv
// Running Ethernet CRC32 register: cleared to all-ones, advanced one byte per
// enable. The raw register is exported; the caller inverts it for the FCS.
module eth_mac_crc32
  import eth_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        crc_clear_i,
  input  logic        crc_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  // CRC accumulator: clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      crc_q <= '1;
    end else if (crc_clear_i) begin
      crc_q <= '1;
    end else if (crc_en_i) begin
      crc_q <= crc32_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit path: AXI-Stream frame in, GMII out with preamble,
// SFD, zero padding, FCS and inter-frame gap.
//
// Handshake: a byte moves on s_axis when s_axis_tvalid && s_axis_tready are
// both high at a rising clk edge. s_axis_tready is registered and never
// depends on s_axis_tvalid in the same cycle. It is high while the wire shows
// the SFD or a data byte (DATA) and while a failed frame is drained; a byte
// accepted in one cycle is on gmii_txd during the next cycle.
//
// State naming: state_q is the control state deciding what the registered
// GMII outputs carry in the following cycle.
module eth_mac_tx
  import eth_mac_pkg::*;
#(
  parameter int PREAMBLE_BYTES = PREAMBLE_BYTES_DEF,
  parameter int MIN_FRAME_SIZE = MIN_FRAME_SIZE_DEF,
  parameter int MAX_FRAME_SIZE = MAX_FRAME_SIZE_DEF,
  parameter int IFG_BYTES      = IFG_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic [15:0] tx_frame_count,
  output logic [15:0] tx_error_count,
  output logic [2:0]  tx_state_dbg
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] PRE_CNT_LAST = CNT_W'(PREAMBLE_BYTES);
  localparam logic [CNT_W-1:0] FCS_CNT_LAST = CNT_W'(FCS_BYTES - 1);
  localparam logic [CNT_W-1:0] IFG_CNT_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [10:0]      PAD_TARGET   = 11'(MIN_FRAME_SIZE - FCS_BYTES);
  localparam logic [10:0]      ABORT_BYTE   = 11'(MAX_FRAME_SIZE - 3);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             en_q, en_d;
  logic             er_q, er_d;
  logic             tready_q, tready_d;
  logic             busy_q;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             hs;
  logic             crc_en;
  logic             crc_clear;
  logic [31:0]      crc_w;
  logic [31:0]      fcs_w;

  assign hs        = s_axis_tvalid && tready_q;
  assign crc_clear = (state_q == ST_IDLE);
  assign fcs_w     = ~crc_w;

  // CRC covers exactly the data and pad bytes being driven onto the wire.
  eth_mac_crc32 u_crc (
    .clk         (clk),
    .rst_ni      (~rst),
    .crc_clear_i (crc_clear),
    .crc_en_i    (crc_en),
    .data_i      (txd_d),
    .crc_o       (crc_w)
  );

  // Next-state and next-output decode; every output register has a default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    txd_d       = 8'h00;
    en_d        = 1'b0;
    er_d        = 1'b0;
    tready_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    crc_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        byte_cnt_d = 11'd0;
        if (s_axis_tvalid) begin
          state_d = ST_PREAMBLE;
          txd_d   = PREAMBLE_BYTE;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == PRE_CNT_LAST) begin
          txd_d    = SFD_BYTE;
          tready_d = 1'b1;
          state_d  = ST_SFD;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SFD, ST_DATA: begin
        en_d = 1'b1;
        if (hs) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          txd_d      = s_axis_tdata;
          if (byte_cnt_d == ABORT_BYTE) begin
            // Oversize: flag the byte and stop the frame.
            er_d = 1'b1;
            if (s_axis_tlast) begin
              state_d   = ST_IFG;
              cnt_d     = '0;
              err_cnt_d = err_cnt_q + 16'd1;
            end else begin
              state_d  = ST_DRAIN;
              tready_d = 1'b1;
            end
          end else begin
            crc_en = 1'b1;
            if (s_axis_tlast) begin
              state_d = (byte_cnt_d < PAD_TARGET) ? ST_PAD : ST_FCS;
              cnt_d   = '0;
            end else begin
              state_d  = ST_DATA;
              tready_d = 1'b1;
            end
          end
        end else begin
          // Underrun: one errored byte on the wire, then swallow the rest.
          er_d     = 1'b1;
          state_d  = ST_DRAIN;
          tready_d = 1'b1;
        end
      end
      ST_PAD: begin
        en_d       = 1'b1;
        crc_en     = 1'b1;
        byte_cnt_d = byte_cnt_q + 11'd1;
        if (byte_cnt_d == PAD_TARGET) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end
      end
      ST_FCS: begin
        en_d  = 1'b1;
        txd_d = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == FCS_CNT_LAST) begin
          state_d     = ST_IFG;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        tready_d = 1'b1;
        if (hs && s_axis_tlast) begin
          tready_d  = 1'b0;
          state_d   = ST_IFG;
          cnt_d     = '0;
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      ST_IFG: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == IFG_CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered GMII/stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      byte_cnt_q  <= 11'd0;
      txd_q       <= 8'h00;
      en_q        <= 1'b0;
      er_q        <= 1'b0;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      txd_q       <= txd_d;
      en_q        <= en_d;
      er_q        <= er_d;
      tready_q    <= tready_d;
      busy_q      <= (state_d != ST_IDLE);
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign gmii_txd       = txd_q;
  assign gmii_tx_en     = en_q;
  assign gmii_tx_er     = er_q;
  assign tx_busy        = busy_q;
  assign tx_frame_count = frame_cnt_q;
  assign tx_error_count = err_cnt_q;
  assign tx_state_dbg   = state_q;

endmodule
